// File: rtl/stopwatch_pkg.sv
// Shared state type, counter width and small helpers for the stopwatch/countdown timer.
package stopwatch_pkg;

  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a prescaler that must hold 0..div-1.
  function automatic int presc_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  // Load values beyond a stage's range clamp to that stage's largest legal value.
  function automatic logic [CNT_W-1:0] sat_field(input logic [CNT_W-1:0] val, input int modulus);
    if (int'(val) >= modulus) begin
      return CNT_W'(modulus - 1);
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/stopwatch_timer_if.sv
// Control, preset and display signals between the button conditioning, the timer and the display driver.
interface stopwatch_timer_if;
  import stopwatch_pkg::*;

  logic             run;
  logic             clear;
  logic             mode;
  logic             load;
  logic             lap;
  logic [CNT_W-1:0] preset_min;
  logic [CNT_W-1:0] preset_sec;
  logic [CNT_W-1:0] preset_sub;
  logic [CNT_W-1:0] out_min;
  logic [CNT_W-1:0] out_sec;
  logic [CNT_W-1:0] out_sub;
  logic             tick;
  logic             ovf;
  logic             done;
  logic             running;

  modport master (
    output run, clear, mode, load, lap, preset_min, preset_sec, preset_sub,
    input  out_min, out_sec, out_sub, tick, ovf, done, running
  );

  modport slave (
    input  run, clear, mode, load, lap, preset_min, preset_sec, preset_sub,
    output out_min, out_sec, out_sub, tick, ovf, done, running
  );

endinterface

// File: rtl/mod_counter.sv
// One modulo-MOD up/down stage: clear beats load beats count; co flags carry (up) or borrow (down).
module mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             clr,
  output logic [CNT_W-1:0] q,
  output logic             co
);
  localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] q_r;
  logic [CNT_W-1:0] q_next_s;

  assign q  = q_r;
  assign co = en && (dir ? (q_r == CNT_ZERO) : (q_r == MAX_VAL));

  // Next count value.
  always_comb begin
    q_next_s = q_r;
    if (clr) begin
      q_next_s = CNT_ZERO;
    end else if (ld) begin
      q_next_s = sat_field(ld_val, MOD);
    end else if (en) begin
      if (dir) begin
        q_next_s = (q_r == CNT_ZERO) ? MAX_VAL : (q_r - CNT_ONE);
      end else begin
        q_next_s = (q_r == MAX_VAL) ? CNT_ZERO : (q_r + CNT_ONE);
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= CNT_ZERO;
    end else begin
      q_r <= q_next_s;
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch / countdown timer: a clock-enable prescaler drives three cascaded modulo stages,
// with pause, lap hold, wrap pulse and expiry indication.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int SUB_MOD  = 100,
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60
) (
  input logic              clk,
  input logic              rst,
  stopwatch_timer_if.slave bus
);
  localparam int PW = presc_w(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [PW-1:0]    presc_r;
  logic [PW-1:0]    presc_cnt_s;
  logic [PW-1:0]    presc_next_s;
  logic             tick_r;
  logic             running_r;
  logic             done_r;
  logic             dir_r;
  logic             hold_on_r;
  logic [CNT_W-1:0] hold_min_r;
  logic [CNT_W-1:0] hold_sec_r;
  logic [CNT_W-1:0] hold_sub_r;
  logic [CNT_W-1:0] q_min_s;
  logic [CNT_W-1:0] q_sec_s;
  logic [CNT_W-1:0] q_sub_s;
  logic             co_sub_s;
  logic             co_sec_s;
  logic             co_min_s;
  logic             load_ok_s;
  logic             zero_s;
  logic             last_s;
  logic             done_hit_s;
  logic             cnt_en_s;
  logic             lap_ok_s;

  assign load_ok_s   = bus.load && !bus.clear && (state_r != RUN);
  assign zero_s      = (q_min_s == CNT_ZERO) && (q_sec_s == CNT_ZERO) && (q_sub_s == CNT_ZERO);
  assign last_s      = (q_min_s == CNT_ZERO) && (q_sec_s == CNT_ZERO) && (q_sub_s == CNT_ONE);
  // A down count already at zero must not borrow; it only reports expiry.
  assign done_hit_s  = tick_r && dir_r && (zero_s || last_s);
  assign cnt_en_s    = tick_r && !(dir_r && zero_s);
  assign lap_ok_s    = bus.lap && (state_r != IDLE);
  assign presc_cnt_s = (state_r == RUN) ? ((presc_r == PRESC_LAST) ? PRESC_ZERO : (presc_r + PRESC_ONE))
                                        : presc_r;

  // Next state and prescaler; clear and an accepted load both force IDLE with a fresh prescaler.
  always_comb begin
    state_next_s = state_r;
    presc_next_s = presc_cnt_s;
    case (state_r)
      IDLE:  state_next_s = bus.run ? RUN : IDLE;
      RUN: begin
        if (done_hit_s) begin
          state_next_s = DONE;
        end else if (!bus.run) begin
          state_next_s = PAUSE;
        end else begin
          state_next_s = RUN;
        end
      end
      PAUSE:   state_next_s = bus.run ? RUN : PAUSE;
      DONE:    state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
    if (bus.clear || load_ok_s) begin
      state_next_s = IDLE;
      presc_next_s = PRESC_ZERO;
    end else begin
      presc_next_s = presc_cnt_s;
    end
  end

  // State, prescaler and status flags, all registered from the next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      presc_r   <= PRESC_ZERO;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
      dir_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      presc_r   <= presc_next_s;
      tick_r    <= (state_next_s == RUN) && (presc_next_s == PRESC_LAST);
      running_r <= (state_next_s == RUN);
      done_r    <= (state_next_s == DONE);
      if ((state_r == IDLE) && (state_next_s == RUN)) begin
        dir_r <= bus.mode;
      end
    end
  end

  // Lap hold: first pulse snapshots the displayed count, the next releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_on_r  <= 1'b0;
      hold_min_r <= CNT_ZERO;
      hold_sec_r <= CNT_ZERO;
      hold_sub_r <= CNT_ZERO;
    end else if (bus.clear || load_ok_s) begin
      hold_on_r <= 1'b0;
    end else if (lap_ok_s) begin
      hold_on_r <= !hold_on_r;
      if (!hold_on_r) begin
        hold_min_r <= q_min_s;
        hold_sec_r <= q_sec_s;
        hold_sub_r <= q_sub_s;
      end
    end
  end

  mod_counter #(.MOD(SUB_MOD)) u_sub (
    .clk(clk), .rst(rst), .en(cnt_en_s), .dir(dir_r), .ld(load_ok_s),
    .ld_val(bus.preset_sub), .clr(bus.clear), .q(q_sub_s), .co(co_sub_s)
  );

  mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk(clk), .rst(rst), .en(co_sub_s), .dir(dir_r), .ld(load_ok_s),
    .ld_val(bus.preset_sec), .clr(bus.clear), .q(q_sec_s), .co(co_sec_s)
  );

  mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk(clk), .rst(rst), .en(co_sec_s), .dir(dir_r), .ld(load_ok_s),
    .ld_val(bus.preset_min), .clr(bus.clear), .q(q_min_s), .co(co_min_s)
  );

  assign bus.out_min = hold_on_r ? hold_min_r : q_min_s;
  assign bus.out_sec = hold_on_r ? hold_sec_r : q_sec_s;
  assign bus.out_sub = hold_on_r ? hold_sub_r : q_sub_s;
  assign bus.tick    = tick_r;
  assign bus.ovf     = co_min_s && !dir_r;
  assign bus.done    = done_r;
  assign bus.running = running_r;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench for stopwatch_timer: directed scenarios plus random stimulus against a total-count reference model.
module tb_stopwatch_timer;
  import stopwatch_pkg::*;

  localparam int TD   = 4;
  localparam int SUBM = 10;
  localparam int SECM = 6;
  localparam int MINM = 3;
  localparam int TOT  = SUBM * SECM * MINM;

  logic clk = 1'b0;
  logic rst;

  stopwatch_timer_if bus ();

  stopwatch_timer #(.TICK_DIV(TD), .SUB_MOD(SUBM), .SEC_MOD(SECM), .MIN_MOD(MINM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] mn;
    logic [6:0] sc;
    logic [6:0] sb;
    logic       tk;
    logic       ov;
    logic       dn;
    logic       rn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: one integer total of sub-units, state 0=idle 1=run 2=pause 3=done.
  int m_state, m_presc, m_total, m_hold_total;
  bit m_dir, m_hold;

  function automatic int satv(input int v, input int md);
    return (v >= md) ? md - 1 : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_total = 0; m_hold_total = 0; m_dir = 1'b0; m_hold = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit c, input bit md, input bit l, input bit lp,
                            input int pm, input int ps, input int pu);
    bit tick_now;
    bit fin;
    tick_now = (m_state == 1) && (m_presc == TD - 1);
    fin = 1'b0;
    if (c) begin
      m_state = 0; m_presc = 0; m_total = 0; m_hold = 1'b0;
    end else if (l && m_state != 1) begin
      m_total = satv(pm, MINM) * SECM * SUBM + satv(ps, SECM) * SUBM + satv(pu, SUBM);
      m_presc = 0; m_state = 0; m_hold = 1'b0;
    end else begin
      if (lp && m_state != 0) begin
        if (!m_hold) m_hold_total = m_total;
        m_hold = !m_hold;
      end
      case (m_state)
        0: if (r) begin m_state = 1; m_dir = md; end
        1: begin
          m_presc = (m_presc + 1) % TD;
          if (tick_now) begin
            if (!m_dir) begin
              m_total = (m_total + 1) % TOT;
            end else begin
              if (m_total > 0) m_total = m_total - 1;
              fin = (m_total == 0);
            end
          end
          if (fin) m_state = 3;
          else if (!r) m_state = 2;
        end
        2: if (r) m_state = 1;
        default: ;
      endcase
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int shown;
    shown = m_hold ? m_hold_total : m_total;
    e.mn = 7'(shown / (SECM * SUBM));
    e.sc = 7'((shown / SUBM) % SECM);
    e.sb = 7'(shown % SUBM);
    e.tk = (m_state == 1) && (m_presc == TD - 1);
    e.ov = e.tk && !m_dir && (m_total == TOT - 1);
    e.dn = (m_state == 3);
    e.rn = (m_state == 1);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_time(input string name, input int mn, input int sc, input int sb);
    chk({name, ".min"}, int'(bus.out_min), mn);
    chk({name, ".sec"}, int'(bus.out_sec), sc);
    chk({name, ".sub"}, int'(bus.out_sub), sb);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, queue its expectation.
  task automatic step(input bit r, input bit c, input bit md, input bit l, input bit lp,
                      input int pm, input int ps, input int pu);
    bus.run = r; bus.clear = c; bus.mode = md; bus.load = l; bus.lap = lp;
    bus.preset_min = 7'(pm); bus.preset_sec = 7'(ps); bus.preset_sub = 7'(pu);
    @(posedge clk);
    model_step(r, c, md, l, lp, pm, ps, pu);
    exp_q.push_back(expect_now());
    #1;
  endtask

  task automatic run_n(input int n, input bit md);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, md, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst.min", int'(bus.out_min), 0);
    chk("async_rst.sec", int'(bus.out_sec), 0);
    chk("async_rst.sub", int'(bus.out_sub), 0);
    chk("async_rst.flags", int'({bus.tick, bus.ovf, bus.done, bus.running}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Monitor: compare the DUT against the oldest queued expectation, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if ({bus.out_min, bus.out_sec, bus.out_sub, bus.tick, bus.ovf, bus.done, bus.running} !== mon_e) begin
        n_errors++;
        $display("FAIL scoreboard @%0t: got %0d:%0d:%0d tick=%b ovf=%b done=%b running=%b, expected %0d:%0d:%0d tick=%b ovf=%b done=%b running=%b",
                 $time, bus.out_min, bus.out_sec, bus.out_sub, bus.tick, bus.ovf, bus.done, bus.running,
                 mon_e.mn, mon_e.sc, mon_e.sb, mon_e.tk, mon_e.ov, mon_e.dn, mon_e.rn);
      end
    end
  end

  initial begin
    int ticks;
    int ovfs;
    bit r;
    rst = 1'b0;
    bus.run = 1'b0; bus.clear = 1'b0; bus.mode = 1'b0; bus.load = 1'b0; bus.lap = 1'b0;
    bus.preset_min = 7'd0; bus.preset_sec = 7'd0; bus.preset_sub = 7'd0;
    model_reset();
    @(posedge clk);
    #1;
    chk_time("reset", 0, 0, 0);
    chk("reset.flags", int'({bus.tick, bus.ovf, bus.done, bus.running}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Up count: ten ticks, one every TD cycles.
    ticks = 0;
    for (int i = 0; i < 41; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      if (bus.tick) ticks++;
    end
    chk("up.ticks", ticks, 10);
    chk_time("up", 0, 1, 0);

    // Pause after two prescaler cycles; the partial tick survives the pause.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk_time("pause.hold", 0, 1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("pause.resume_tick0", int'(bus.tick), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("pause.resume_tick1", int'(bus.tick), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk_time("pause.after", 0, 1, 1);

    // Wrap from the maximum count.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5, 9);
    chk_time("wrap.load", 2, 5, 9);
    ovfs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      if (bus.ovf) ovfs++;
    end
    chk("wrap.ovf_count", ovfs, 1);
    chk_time("wrap", 0, 0, 0);
    chk("wrap.running", int'(bus.running), 1);

    // Countdown to expiry, then stays at zero.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 2);
    run_n(5, 1'b1);
    chk_time("down.one", 0, 0, 1);
    run_n(4, 1'b1);
    chk_time("down.zero", 0, 0, 0);
    chk("down.done", int'(bus.done), 1);
    chk("down.running", int'(bus.running), 0);
    run_n(10, 1'b1);
    chk_time("down.stay", 0, 0, 0);
    chk("down.done_stay", int'(bus.done), 1);

    // Lap hold while counting continues.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_n(13, 1'b0);
    chk_time("lap.before", 0, 0, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    run_n(20, 1'b0);
    chk_time("lap.frozen", 0, 0, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    chk_time("lap.release", 0, 0, 8);

    // Clear outranks load; out-of-range presets saturate.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 3);
    chk_time("prio.clear", 0, 0, 0);
    chk("prio.flags", int'({bus.done, bus.running}), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 70, 0);
    chk_time("sat", 0, 5, 0);

    // Asynchronous reset mid-run.
    run_n(30, 1'b0);
    reset_dut();

    // Randomised traffic against the model.
    r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) r = !r;
      step(r, ($urandom_range(0, 249) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 49) == 0), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 12)));
      if ($urandom_range(0, 1499) == 0) reset_dut();
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer.md
# stopwatch_timer

Parametrised three-stage stopwatch/countdown timer that replaces the single-stage gated-clock counter with a clock-enable design. A programmable prescaler produces a base tick on the system clock, and the tick drives cascaded modulo counters (sub-unit, seconds, minutes). Each counter counts up (stopwatch) or down (timer with preset load). The block sits between the board clock/button conditioning and the 7-segment display driver, and adds pause, lap hold, wrap and expiry indication.

## Interface
- TICK_DIV, 100: clk cycles per base tick; range 2..4096.
- SUB_MOD, 100: sub-unit stage modulus; range 2..128.
- SEC_MOD, 60: seconds stage modulus; range 2..128.
- MIN_MOD, 60: minutes stage modulus; range 2..128.

Ports:
- clk  in  1  system clock; every flop uses this clock and no derived or gated clocks.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level input: 1 means count, 0 means pause.
- clear  in  1  one-cycle pulse that zeroes counters and prescaler.
- mode  in  1  0 means up (stopwatch), 1 means down (timer); sampled only in IDLE.
- load  in  1  one-cycle pulse that copies the preset_* inputs into the counters.
- preset_min / preset_sec / preset_sub  in  7 each  load values.
- lap  in  1  one-cycle pulse that toggles lap hold.
- out_min / out_sec / out_sub  out  7 each  displayed value.
- tick  out  1  one-cycle pulse on each base tick that advances the counters.
- ovf  out  1  one-cycle pulse when an up count wraps from its maximum to 0:0:0.
- done  out  1  level, set while in DONE.
- running  out  1  level, set while in RUN.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - goes to RUN when run=1;
  - latches mode on that transition.
- RUN:
  - goes to PAUSE when run=0;
  - in down mode, goes to DONE on the tick that makes the count 0:0:0.
- PAUSE:
  - goes to RUN when run=1;
  - goes to IDLE on clear.
- DONE:
  - goes to IDLE on clear or load.
- Clear in any state returns to IDLE and zeroes counters, prescaler and lap hold.
- Load in IDLE, PAUSE or DONE:
  - counters take the preset values; each field whose value is ≥ its modulus saturates to modulus-1;
  - the prescaler goes to 0;
  - the state goes to IDLE;
  - load in RUN is ignored.
- Priority within a cycle: rst > clear > load > tick.
- Prescaler:
  - counts 0..TICK_DIV-1 only in RUN and holds its value in PAUSE, so the partial tick is kept;
  - tick asserts when prescaler == TICK_DIV-1 in RUN.
- Up mode: sub increments; on wrap SUB_MOD-1→0 it carries into sec; sec wraps SEC_MOD-1→0 and carries into min. At MIN_MOD-1:SEC_MOD-1:SUB_MOD-1 the next tick gives 0:0:0, asserts ovf, and counting continues.
- Down mode: sub decrements; on 0 it borrows and reloads SUB_MOD-1, and likewise up the chain. A tick that produces 0:0:0 enters DONE; counters hold at 0. Starting RUN in down mode at 0:0:0 goes to DONE on the first tick and the counters stay at 0.
- Lap:
  - the first lap pulse freezes the out_* values at the live count while counting continues;
  - the second lap pulse releases the hold;
  - lap is ignored in IDLE.

## Timing
- Reset values: all out_* = 0, tick = ovf = done = running = 0, state = IDLE, prescaler = 0, lap hold off.
- Counters update on the clk edge where tick is high. Without lap hold, out_* show the new value from that same edge, with zero added latency.
- The run edge takes effect on the next clk edge. The first tick comes TICK_DIV cycles after entering RUN from a zero prescaler.
- done and running are registered from the state and change on the edge that changes the state.
- ovf is coincident with the wrapping tick.
- clear and load act on the edge where they are sampled high; out_* show the result the same edge.
- Reset asserted mid-count forces every output to its reset value immediately (asynchronously).

## Structure
- Package stopwatch_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the CNT_W = 7 width constant;
  - the prescaler width function (clog2 of TICK_DIV).
- Sub-module mod_counter (parameter MOD):
  - inputs: en, dir, ld, ld_val, clr;
  - outputs: q, and co (carry/borrow out, combinational on en and the terminal value);
  - instantiated three times and chained through co → en.

## Test plan
- Up count, TICK_DIV=4, SUB_MOD=10, SEC_MOD=6, MIN_MOD=3: run held high for 4×10 cycles → out = 0:1:0, one tick every 4 cycles.
- Wrap: load 2:5:9, run up for one tick → out = 0:0:0, ovf pulses once, running stays 1.
- Countdown: load 0:0:2, mode=1, run → ticks give 0:0:1 then 0:0:0, done=1, state DONE; further ticks leave the count at 0.
- Pause: drop run after 2 prescaler cycles, hold 10 cycles, raise run again → the next tick arrives 2 cycles later and the count does not move while paused.
- Lap: lap at 0:0:3, run 5 more ticks → out stays 0:0:3; second lap → out = 0:0:8.
- Priority and reset: assert clear and load together → counters 0, state IDLE. Load 0:70:0 → sec saturates to 5. Assert rst mid-run → all outputs 0 immediately.
